// File: rtl/ip_codma_mem_responder.sv
// ip_codma_mem_responder: codma bus target backed by a register-array scratch RAM.
// Grants after a programmable latency, streams read beats with optional gaps, absorbs byte-lane writes.
//
// state      | meaning
// IDLE       | waiting for a read/write request; captures addr/size/direction
// GRANT_WAIT | counting down to the one-cycle grant pulse
// RD_BEAT    | presenting one read beat (valid=1)
// RD_GAP     | idle spacing between read beats
// WR_BEAT    | absorbing write beats on write_valid, may stall indefinitely
// ERR        | one-cycle error response for an illegal request
module ip_codma_mem_responder #(
    parameter int MEM_DEPTH     = 256,
    parameter int GRANT_LATENCY = 2,
    parameter int READ_GAP      = 0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        bus_read_i,
    input  logic        bus_write_i,
    input  logic [3:0]  bus_size_i,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_write_valid_i,
    input  logic [63:0] bus_write_data_i,
    output logic        bus_grant_o,
    output logic        bus_read_valid_o,
    output logic [63:0] bus_read_data_o,
    output logic        bus_error_o,
    output logic        busy_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_WAIT,
        RD_BEAT,
        RD_GAP,
        WR_BEAT,
        ERR
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       beats_q, beats_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             is_read_q, is_read_d;
    logic [3:0]       size_q, size_d;
    logic [2:0]       lane_q, lane_d;
    logic [63:0]      rd_data_q;
    logic [63:0]      mem_q [MEM_DEPTH];

    logic             req_legal;
    logic [2:0]       req_beats;
    logic             wr_fire;
    logic [7:0]       wr_be;
    logic             grant;
    logic             unused_addr;

    // Upper address bits are intentionally dropped: the word index wraps modulo the array.
    assign unused_addr = ^bus_addr_i[31:3+IDX_W];

    always_comb begin
        req_legal = 1'b0;
        req_beats = 3'd1;
        case (bus_size_i)
            4'd0:    req_legal = 1'b1;
            4'd1:    req_legal = (bus_addr_i[0] == 1'b0);
            4'd2:    req_legal = (bus_addr_i[1:0] == 2'b00);
            4'd3:    req_legal = (bus_addr_i[2:0] == 3'b000);
            4'd4: begin
                req_legal = (bus_addr_i[2:0] == 3'b000);
                req_beats = 3'd2;
            end
            4'd5: begin
                req_legal = (bus_addr_i[2:0] == 3'b000);
                req_beats = 3'd4;
            end
            default: req_legal = 1'b0;
        endcase
    end

    assign wr_fire = (state_q == WR_BEAT) && bus_write_valid_i;

    always_comb begin
        case (size_q)
            4'd0:    wr_be = 8'h01 << lane_q;
            4'd1:    wr_be = 8'h03 << lane_q;
            4'd2:    wr_be = 8'h0F << lane_q;
            default: wr_be = 8'hFF;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beats_d   = beats_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        size_d    = size_q;
        lane_d    = lane_q;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_read_i || bus_write_i) begin
                    is_read_d = bus_read_i;
                    size_d    = bus_size_i;
                    lane_d    = bus_addr_i[2:0];
                    idx_d     = bus_addr_i[3 +: IDX_W];
                    beats_d   = req_beats;
                    cnt_d     = 4'(GRANT_LATENCY - 1);
                    state_d   = req_legal ? GRANT_WAIT : ERR;
                end
            end
            GRANT_WAIT: begin
                if (cnt_q == 4'd0) begin
                    grant   = 1'b1;
                    state_d = is_read_q ? RD_BEAT : WR_BEAT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_BEAT: begin
                idx_d   = idx_q + 1'b1;
                beats_d = beats_q - 3'd1;
                if (beats_q == 3'd1) begin
                    state_d = IDLE;
                end else if (READ_GAP > 0) begin
                    state_d = RD_GAP;
                    cnt_d   = 4'(READ_GAP - 1);
                end
            end
            RD_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = RD_BEAT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_BEAT: begin
                if (bus_write_valid_i) begin
                    idx_d   = idx_q + 1'b1;
                    beats_d = beats_q - 3'd1;
                    if (beats_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            size_q    <= '0;
            lane_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            beats_q   <= beats_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            size_q    <= size_d;
            lane_q    <= lane_d;
            // Load the beat one cycle ahead so data and valid appear together.
            if (state_d == RD_BEAT) begin
                rd_data_q <= mem_q[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= bus_write_data_i[8*b +: 8];
                end
            end
        end
    end

    assign bus_grant_o      = grant;
    assign bus_read_valid_o = (state_q == RD_BEAT);
    assign bus_read_data_o  = rd_data_q;
    assign bus_error_o      = (state_q == ERR);
    assign busy_o           = (state_q != IDLE);

    a_grant_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus_grant_o |-> !bus_read_valid_o && !bus_error_o);
    a_grant_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus_grant_o |-> state_q == GRANT_WAIT);

endmodule

// File: doc/ip_codma_mem_responder.md
Name: ip_codma_mem_responder

Overview:
- Memory-side responder (bus target) for the codma memory bus.
- Accepts read and write requests from the codma initiator and issues grant after a programmable latency.
- Returns or absorbs 64-bit data beats from an internal register-array memory.
- Used as the bus endpoint in subsystem simulation and as a simple on-chip scratch RAM.

Parameters:
- MEM_DEPTH, 256: number of 64-bit words; power of two, minimum 4.
- GRANT_LATENCY, 2: cycles from request seen in IDLE to grant pulse; range 1..15.
- READ_GAP, 0: idle cycles inserted between consecutive read beats; range 0..3.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- bus_read_i  in  1  read request; held high by the initiator until bus_grant_o.
- bus_write_i  in  1  write request; held high by the initiator until bus_grant_o.
- bus_size_i  in  4  transfer size, 2^size bytes; 0..5 legal; 9 means idle.
- bus_addr_i  in  32  byte address.
- bus_write_valid_i  in  1  write beat valid.
- bus_write_data_i  in  64  write beat data.
- bus_grant_o  out  1  one-cycle grant pulse.
- bus_read_valid_o  out  1  read beat valid.
- bus_read_data_o  out  64  read beat data.
- bus_error_o  out  1  one-cycle error response pulse.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0.
  - State IDLE; counters 0.
  - Memory contents are not reset and are undefined until written.
- States: IDLE, GRANT_WAIT, RD_BEAT, RD_GAP, WR_BEAT, ERR.
- Request capture in IDLE:
  - A cycle with bus_read_i or bus_write_i high captures addr, size and direction.
  - Read wins if both are high; the write stays pending because the initiator keeps it asserted.
- Beat count:
  - size<=3 gives 1 beat; size 4 gives 2 beats; size 5 gives 4 beats.
  - The word index is addr[3 +: log2(MEM_DEPTH)]; the upper bits are ignored, so addresses wrap modulo memory size.
  - Each beat increments the word index, wrapping from MEM_DEPTH-1 to 0.
- Illegal request:
  - Covers size>5, or an address not aligned to min(2^size,8) bytes.
  - IDLE goes to ERR instead of GRANT_WAIT.
  - ERR pulses bus_error_o for 1 cycle with no grant, then returns to IDLE.
- GRANT_WAIT:
  - Counts GRANT_LATENCY-1 cycles, then bus_grant_o=1 for exactly 1 cycle.
  - Total latency from request capture to grant is GRANT_LATENCY cycles.
  - On the grant cycle, moves to RD_BEAT or WR_BEAT.
- RD_BEAT:
  - The first read beat appears the cycle after the grant.
  - bus_read_valid_o=1 with the registered word mem[idx].
  - If READ_GAP>0 and beats remain, goes to RD_GAP for READ_GAP cycles with valid=0.
  - After the last beat, goes to IDLE.
  - The initiator cannot back-pressure reads.
  - bus_read_data_o holds its last value when valid=0.
- WR_BEAT:
  - Each cycle with bus_write_valid_i=1 writes one beat and decrements the count.
  - write_valid=0 stalls indefinitely; there is no timeout.
  - After the last beat, goes to IDLE next cycle; extra write_valid beats in IDLE are ignored.
  - Sub-word writes (size 0..2) update only the 2^size bytes at lane addr[2:0], taken from the same lanes of write_data; other bytes are preserved.
  - Sizes 3..5 write full 64-bit words.
- No read-during-write hazard: a single transfer is active at a time.
- Request input levels during an active transfer are ignored.
- Back-to-back transfers: a request held high on the cycle the state returns to IDLE is captured that cycle. Minimum spacing between transfers is 1 idle cycle.
- Reset mid-transfer aborts immediately:
  - Partial write beats already committed remain in memory.
  - No grant, valid or error pulse follows the abort.
- Sequencing assertions:
  - Grant never coincides with read_valid or error.
  - Grant only occurs in GRANT_WAIT.

Test Plan:
- Write size 5 at addr 0x40: data 0x11..,0x22..,0x33..,0x44.. with write_valid continuous, GRANT_LATENCY 2 -> grant 2 cycles after request; words 8..11 hold the data; busy_o drops 1 cycle after the 4th beat.
- Read size 5 at addr 0x40 after the write -> grant, then 4 consecutive read_valid beats 0x11..,0x22..,0x33..,0x44..; with READ_GAP=1, valid on every second cycle.
- Write size 1 data 0xBEEF at addr 0x42 over a word preset to 0 -> word 8 reads 0x0000_0000_BEEF_0000; other bytes unchanged.
- read and write both high in the same cycle -> read granted and completed first; write granted afterwards without being deasserted.
- Size 6 request, or size 3 at addr 0x44 -> bus_error_o single pulse, no grant, memory unchanged, IDLE next cycle.
- Size 5 write at word MEM_DEPTH-2 with a write_valid stall of 3 cycles mid-burst, then reset asserted after beat 3 -> beats land at MEM_DEPTH-2, MEM_DEPTH-1, 0; beat 4 is absent; all outputs 0 immediately on reset.
